// File: rtl/conv_layer_sched.sv
// Layer scheduler for the 3x3 convolve engine: primes three rows, then per output row fetches
// `stride` new rows, starts the convolve with the row's destination address and waits for completion.
module conv_layer_sched #(
  parameter int IMG_W           = 28,
  parameter int ROW_W           = 8,
  parameter int DEST_ADDR_WIDTH = 10,
  parameter int TIMEOUT         = 1023
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_stride,
  input  logic [ROW_W-1:0]           cmd_img_rows,
  input  logic [DEST_ADDR_WIDTH-1:0] cmd_dest_base,
  input  logic                       abort,
  output logic                       fetch_req,
  output logic [ROW_W-1:0]           fetch_row,
  input  logic                       fetch_ack,
  output logic                       conv_start,
  output logic [1:0]                 conv_stride,
  output logic [DEST_ADDR_WIDTH-1:0] conv_dest_addr,
  input  logic                       conv_done,
  output logic                       busy,
  output logic                       layer_done,
  output logic                       err,
  output logic [ROW_W-1:0]           out_row_cnt
);
  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam int STEP1 = (IMG_W - 3) + 1;
  localparam int STEP2 = ((IMG_W - 3) >> 1) + 1;

  typedef enum logic [2:0] {IDLE, PRIME, START, WAIT, FETCH, FINISH} state_t;

  state_t                     state, state_nxt;
  logic [1:0]                 stride_q;
  logic [ROW_W-1:0]           n_out_q, row_q, out_cnt_q;
  logic [DEST_ADDR_WIDTH-1:0] step_q, dest_q;
  logic [1:0]                 phase_cnt;
  logic                       gap_q, err_q;
  logic [TW-1:0]              wait_cnt;

  logic accept, cmd_ok, ack_hit, phase_last, last_row, timeout_hit, abort_hit;

  assign accept      = cmd_valid & cmd_ready;
  assign cmd_ok      = (cmd_stride == 2'd1 || cmd_stride == 2'd2) && (cmd_img_rows >= ROW_W'(3));
  assign ack_hit     = fetch_req & fetch_ack;
  assign phase_last  = (state == PRIME) ? (phase_cnt == 2'd2) : (phase_cnt == stride_q - 2'd1);
  assign last_row    = (out_cnt_q + ROW_W'(1)) == n_out_q;
  assign timeout_hit = (state == WAIT) && !conv_done && (wait_cnt == TW'(TIMEOUT - 1));
  assign abort_hit   = abort && (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:        if (accept && cmd_ok) state_nxt = PRIME;
      PRIME,
      FETCH:       if (ack_hit && phase_last) state_nxt = START;
      START:       state_nxt = WAIT;
      WAIT:        if (conv_done)        state_nxt = last_row ? FINISH : FETCH;
                   else if (timeout_hit) state_nxt = IDLE;
      FINISH:      state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
    if (abort_hit) state_nxt = IDLE;
  end

  always_comb begin
    cmd_ready  = (state == IDLE);
    busy       = (state != IDLE);
    fetch_req  = (state == PRIME || state == FETCH) && !gap_q;
    conv_start = (state == START);
    layer_done = (state == FINISH);
  end

  // gap_q forces one idle cycle on fetch_req after every accepted fetch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stride_q  <= '0;
      n_out_q   <= '0;
      step_q    <= '0;
      dest_q    <= '0;
      row_q     <= '0;
      out_cnt_q <= '0;
      phase_cnt <= '0;
      gap_q     <= 1'b0;
      wait_cnt  <= '0;
      err_q     <= 1'b0;
    end else begin
      gap_q <= ack_hit;
      err_q <= (accept && !cmd_ok) || abort_hit || timeout_hit;
      if (accept) begin
        stride_q  <= cmd_stride;
        n_out_q   <= ((cmd_img_rows - ROW_W'(3)) >> (cmd_stride == 2'd2)) + ROW_W'(1);
        step_q    <= (cmd_stride == 2'd2) ? DEST_ADDR_WIDTH'(STEP2) : DEST_ADDR_WIDTH'(STEP1);
        dest_q    <= cmd_dest_base;
        row_q     <= '0;
        out_cnt_q <= '0;
        phase_cnt <= '0;
        gap_q     <= 1'b0;
      end
      if (ack_hit) begin
        row_q     <= row_q + ROW_W'(1);
        phase_cnt <= phase_last ? 2'd0 : phase_cnt + 2'd1;
      end
      if (state == START) wait_cnt <= TW'(1);
      else if (state == WAIT) wait_cnt <= wait_cnt + TW'(1);
      if (state == WAIT && conv_done) begin
        out_cnt_q <= out_cnt_q + ROW_W'(1);
        dest_q    <= dest_q + step_q;
      end
    end
  end

  assign fetch_row      = row_q;
  assign conv_dest_addr = dest_q;
  assign conv_stride    = busy ? stride_q : 2'd0;
  assign err            = err_q;
  assign out_row_cnt    = out_cnt_q;
endmodule

// File: tb/tb_conv_layer_sched.sv
// Scoreboard bench for conv_layer_sched: stimulus pushes expected fetch/start/done/err events,
// a negedge monitor pops and compares them as the scheduler emits them.
module tb_conv_layer_sched;
  localparam int TIMEOUT = 1023;
  localparam int EV_FETCH = 0, EV_START = 1, EV_DONE = 2, EV_ERR = 3;

  logic       clk = 0, rst = 1;
  logic       cmd_valid = 0, cmd_ready;
  logic [1:0] cmd_stride = 0;
  logic [7:0] cmd_img_rows = 0;
  logic [9:0] cmd_dest_base = 0;
  logic       abort = 0;
  logic       fetch_req, fetch_ack = 0;
  logic [7:0] fetch_row;
  logic       conv_start, conv_done = 0;
  logic [1:0] conv_stride;
  logic [9:0] conv_dest_addr;
  logic       busy, layer_done, err;
  logic [7:0] out_row_cnt;

  conv_layer_sched #(.IMG_W(28), .ROW_W(8), .DEST_ADDR_WIDTH(10), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_stride(cmd_stride), .cmd_img_rows(cmd_img_rows), .cmd_dest_base(cmd_dest_base),
    .abort(abort), .fetch_req(fetch_req), .fetch_row(fetch_row), .fetch_ack(fetch_ack),
    .conv_start(conv_start), .conv_stride(conv_stride), .conv_dest_addr(conv_dest_addr),
    .conv_done(conv_done), .busy(busy), .layer_done(layer_done), .err(err),
    .out_row_cnt(out_row_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { int kind; int val; } ev_t;
  ev_t exp_q[$];
  int  checks = 0, errors = 0;
  int  cyc = 0, last_start_cyc = 0;
  int  exp_stride = 0;
  int  ack_delay = 0;
  bit  chk_stable = 0, withhold = 0;
  logic prev_req = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic push(input int kind, input int val);
    ev_t e;
    e.kind = kind; e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic got_ev(input int kind, input int val);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_event: got kind %0d val %0d expected none", kind, val);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_val", val, e.val);
    end
  endtask

  // Monitor: fetch events are new requests (rising fetch_req), so no race with the ack driver
  always @(negedge clk) begin
    if (!rst) begin
      if (fetch_req && !prev_req) got_ev(EV_FETCH, int'(fetch_row));
      if (conv_start) begin
        got_ev(EV_START, int'(conv_dest_addr));
        chk("conv_stride", int'(conv_stride), exp_stride);
        last_start_cyc = cyc;
      end
      if (layer_done) got_ev(EV_DONE, int'(out_row_cnt));
      if (err) got_ev(EV_ERR, 0);
    end
    prev_req = fetch_req;
  end

  // Line buffer model: acks each request after ack_delay cycles
  initial begin
    logic [7:0] row0;
    forever begin
      @(negedge clk);
      if (fetch_req && !rst) begin
        row0 = fetch_row;
        for (int k = 0; k < ack_delay; k++) begin
          @(negedge clk);
          if (chk_stable) begin
            chk("req_held", int'(fetch_req), 1);
            chk("row_stable", int'(fetch_row), int'(row0));
          end
        end
        fetch_ack = 1;
        @(negedge clk);
        fetch_ack = 0;
      end
    end
  end

  // Convolve model: done three cycles after start unless withheld
  initial begin
    forever begin
      @(negedge clk);
      if (conv_start && !withhold) begin
        repeat (3) @(negedge clk);
        conv_done = 1;
        @(negedge clk);
        conv_done = 0;
      end
    end
  end

  task automatic send(input int s, input int rows, input int base);
    cmd_stride = 2'(s); cmd_img_rows = 8'(rows); cmd_dest_base = 10'(base);
    cmd_valid = 1;
    @(negedge clk);
    cmd_valid = 0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin @(negedge clk); n++; end
    chk(name, exp_q.size() + int'(busy), 0);
    exp_q.delete();
  endtask

  task automatic wait_q_empty(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin @(negedge clk); n++; end
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", int'(cmd_ready), 1);
    chk("rst_outputs", int'({busy, fetch_req, conv_start, layer_done, err}), 0);
    chk("rst_cnt_dest", int'(out_row_cnt) + int'(conv_dest_addr) + int'(conv_stride), 0);
    rst = 0;
    @(negedge clk);

    // s=1 rows=5 base=100
    exp_stride = 1;
    push(EV_FETCH,0); push(EV_FETCH,1); push(EV_FETCH,2); push(EV_START,100);
    push(EV_FETCH,3); push(EV_START,126); push(EV_FETCH,4); push(EV_START,152); push(EV_DONE,3);
    send(1, 5, 100);
    chk("busy_after_accept", int'(busy), 1);
    drain("layer_s1");
    chk("cnt_held", int'(out_row_cnt), 3);
    chk("idle_stride", int'(conv_stride), 0);

    // s=2 rows=7 base=0
    exp_stride = 2;
    push(EV_FETCH,0); push(EV_FETCH,1); push(EV_FETCH,2); push(EV_START,0);
    push(EV_FETCH,3); push(EV_FETCH,4); push(EV_START,13);
    push(EV_FETCH,5); push(EV_FETCH,6); push(EV_START,26); push(EV_DONE,3);
    send(2, 7, 0);
    drain("layer_s2");

    // illegal commands
    push(EV_ERR, 0);
    send(3, 5, 0);
    chk("bad_stride_err", int'(err), 1);
    chk("bad_stride_ready", int'(cmd_ready), 1);
    drain("bad_stride");
    push(EV_ERR, 0);
    send(1, 2, 0);
    chk("bad_rows_err", int'(err), 1);
    chk("bad_rows_busy", int'(busy), 0);
    drain("bad_rows");

    // delayed fetch_ack
    ack_delay = 5; chk_stable = 1; exp_stride = 2;
    push(EV_FETCH,0); push(EV_FETCH,1); push(EV_FETCH,2); push(EV_START,50);
    push(EV_FETCH,3); push(EV_FETCH,4); push(EV_START,63);
    push(EV_FETCH,5); push(EV_FETCH,6); push(EV_START,76); push(EV_DONE,3);
    send(2, 7, 50);
    drain("layer_slow_ack");
    chk_stable = 0;

    // abort while fetching row 3
    exp_stride = 1;
    push(EV_FETCH,0); push(EV_FETCH,1); push(EV_FETCH,2); push(EV_START,100); push(EV_FETCH,3);
    send(1, 5, 100);
    wait_q_empty("reach_fetch3");
    push(EV_ERR, 0);
    abort = 1;
    @(negedge clk);
    abort = 0;
    chk("abort_err", int'(err), 1);
    chk("abort_idle", int'({cmd_ready, busy, fetch_req, conv_start}), 4'b1000);
    repeat (10) @(negedge clk);
    drain("abort");
    ack_delay = 0;

    // wrap: base=1000 s=1 rows=4
    push(EV_FETCH,0); push(EV_FETCH,1); push(EV_FETCH,2); push(EV_START,1000);
    push(EV_FETCH,3); push(EV_START,2); push(EV_DONE,2);
    send(1, 4, 1000);
    drain("layer_wrap");

    // timeout
    withhold = 1;
    push(EV_FETCH,0); push(EV_FETCH,1); push(EV_FETCH,2); push(EV_START,100); push(EV_ERR,0);
    send(1, 5, 100);
    begin
      int n = 0;
      while (!err && n < TIMEOUT + 100) begin @(negedge clk); n++; end
      chk("timeout_seen", int'(err), 1);
      chk("timeout_cycles", cyc - last_start_cyc, TIMEOUT);
    end
    drain("timeout");

    // reset mid-WAIT
    push(EV_FETCH,0); push(EV_FETCH,1); push(EV_FETCH,2); push(EV_START,100);
    send(1, 5, 100);
    wait_q_empty("reach_wait");
    repeat (4) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("rst_wait_idle", int'({cmd_ready, busy, fetch_req, conv_start, err}), 5'b10000);
    rst = 0;
    withhold = 0;
    repeat (3) @(negedge clk);

    // clean layer after reset
    exp_stride = 2;
    push(EV_FETCH,0); push(EV_FETCH,1); push(EV_FETCH,2); push(EV_START,0);
    push(EV_FETCH,3); push(EV_FETCH,4); push(EV_START,13);
    push(EV_FETCH,5); push(EV_FETCH,6); push(EV_START,26); push(EV_DONE,3);
    send(2, 7, 0);
    drain("layer_after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
